mdr_handshake: RTL and testbench
================================

Name: mdr_handshake

Overview:
- Parametrised memory data register for the down-sampling processor datapath.
- Sits between the internal data bus and data memory.
- Latches bus data and writes it to memory, or reads memory data into the register, using a req/ack handshake with timeout.
- Provides a gated bus output and a direct low-slice output to the memory/address path.

Parameters:
BUS_W, 20, internal data bus width
MEM_W, 10, memory data width; must satisfy MEM_W <= BUS_W
TIMEOUT, 15, edges to wait for mem_ack before abort; range 1..255

Ports:
clk  input  1  clock; all state updates on falling edge
rst  input  1  synchronous active-high reset, sampled on falling edge of clk
bus_in  input  BUS_W  data from internal bus
bus_out  output  BUS_W  register value when rdr=1, else all zeros (no tristate)
rdr  input  1  bus output enable
r_direct  output  MEM_W  R[MEM_W-1:0], always driven
mem_write  input  1  command: load bus_in and write to memory
mem_read  input  1  command: read memory into R
mem_wr_req  output  1  write request to memory
mem_rd_req  output  1  read request to memory
mem_wdata  output  MEM_W  write data, equals R[MEM_W-1:0]
mem_rdata  input  MEM_W  read data from memory
mem_ack  input  1  memory completion, one-cycle pulse
busy  output  1  transaction in progress
done  output  1  one-cycle pulse on successful completion
err  output  1  sticky timeout flag

Behaviour:
- Reset values:
  - R = 0.
  - State IDLE.
  - mem_wr_req, mem_rd_req, busy, done, err = 0.
  - Timeout counter = 0.
  - bus_out = 0 regardless of rdr.
- State machine: IDLE, WR_WAIT, RD_WAIT.
- IDLE:
  - mem_write=1 at edge: R <= zero-extended bus_in[MEM_W-1:0]; go WR_WAIT.
  - Else mem_read=1: go RD_WAIT; R is unchanged.
  - Both asserted: write wins; the read is dropped, not queued.
- WR_WAIT:
  - mem_wr_req=1 and busy=1 from the edge after the command.
  - On an edge sampling mem_ack=1: return IDLE; done=1 for the following cycle.
- RD_WAIT:
  - mem_rd_req=1 and busy=1.
  - On an edge sampling mem_ack=1: R <= zero-extended mem_rdata; return IDLE; done=1 for the following cycle.
- Minimum latency: command edge N, ack sampled edge N+1, R valid and busy=0 after edge N+1.
- Timeout:
  - The counter clears on state entry and increments each edge without ack.
  - When the counter reaches TIMEOUT: return IDLE, err <= 1, done stays 0, R is unchanged.
  - For a read, R keeps its old value.
  - Ack on the same edge the counter reaches TIMEOUT counts as success.
- err: cleared only by rst, or by a new accepted command. Accepting a command clears err on that edge.
- Commands received while busy=1 are ignored entirely, with no side effects.
- mem_ack while IDLE is ignored.
- rst asserted mid-transaction: next edge forces IDLE, drops requests, sets R=0, err=0, done=0. No done pulse is issued.
- bus_out and r_direct are combinational from R and rdr. R[BUS_W-1:MEM_W] is always zero unless SIGN_EXT_EN is defined.

Optional Feature:
- Macro: MDR_SIGN_EXT_EN.
- Defined: the value loaded into R (from bus_in slice or mem_rdata) is sign-extended from bit MEM_W-1 to BUS_W. Example: mem_rdata=10'h3F0 gives R=20'hFFFF0.
- Undefined: zero-extension; the same input gives R=20'h003F0.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset then rdr=1 -> bus_out=0, r_direct=0, busy=0, err=0.
2. Write with bus_in=20'hABCDE, mem_write pulse, ack 2 edges later:
   - mem_wr_req high for 2 cycles.
   - mem_wdata=10'h0DE, R=20'h000DE.
   - done pulses once; busy then 0.
3. Read with mem_read pulse, mem_rdata=10'h155, ack at edge N+3 -> R=20'h00155, bus_out=20'h00155 with rdr=1, done pulses once.
4. Read with TIMEOUT=15 and no ack, prior R=20'h00012:
   - err=1 after 15 edges; mem_rd_req drops.
   - R stays 20'h00012; done never pulses.
   - A subsequent accepted mem_write clears err.
5. mem_write and mem_read asserted together with bus_in=20'h00077:
   - Write path taken; R=20'h00077; no read request.
   - A second mem_read during WR_WAIT is ignored.
6. rst asserted during RD_WAIT -> next edge: requests 0, R=0, busy=0, no done. A later mem_ack is ignored.

Source files
------------

// File: rtl/mdr_handshake.sv
// Memory data register with req/ack handshake and timeout; all state changes on the falling clock edge.
// Define MDR_SIGN_EXT_EN to sign-extend loaded values from bit MEM_W-1 instead of zero-extending them.
module mdr_handshake #(
    parameter int BUS_W   = 20,
    parameter int MEM_W   = 10,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] bus_in,
    output logic [BUS_W-1:0] bus_out,
    input  logic             rdr,
    output logic [MEM_W-1:0] r_direct,
    input  logic             mem_write,
    input  logic             mem_read,
    output logic             mem_wr_req,
    output logic             mem_rd_req,
    output logic [MEM_W-1:0] mem_wdata,
    input  logic [MEM_W-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        WR_WAIT,
        RD_WAIT
    } state_e;

    state_e           state_q;
    logic [BUS_W-1:0] dataR_q;
    logic [7:0]       timeoutCnt_q;
    logic             memWrReq_q;
    logic             memRdReq_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [BUS_W-1:0] busLoad_d;
    logic [BUS_W-1:0] memLoad_d;
    logic             timeoutHit;
    logic             unusedBusHi;

    function automatic logic [BUS_W-1:0] extend(input logic [MEM_W-1:0] v);
        logic [BUS_W-1:0] res;
        res            = '0;
        res[MEM_W-1:0] = v;
`ifdef MDR_SIGN_EXT_EN
        for (int i = MEM_W; i < BUS_W; i++) begin
            res[i] = v[MEM_W-1];
        end
`endif
        return res;
    endfunction

    assign busLoad_d  = extend(bus_in[MEM_W-1:0]);
    assign memLoad_d  = extend(mem_rdata);
    assign timeoutHit = (timeoutCnt_q + 8'd1) == 8'(TIMEOUT);

    // Only the low MEM_W bits of the bus are ever stored.
    assign unusedBusHi = ^bus_in;

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dataR_q      <= '0;
            timeoutCnt_q <= '0;
            memWrReq_q   <= 1'b0;
            memRdReq_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_write) begin
                        dataR_q      <= busLoad_d;
                        state_q      <= WR_WAIT;
                        memWrReq_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        err_q        <= 1'b0;
                        timeoutCnt_q <= '0;
                    end else if (mem_read) begin
                        state_q      <= RD_WAIT;
                        memRdReq_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        err_q        <= 1'b0;
                        timeoutCnt_q <= '0;
                    end
                end
                WR_WAIT, RD_WAIT: begin
                    // An ack on the very edge the timeout expires still wins.
                    if (mem_ack) begin
                        if (state_q == RD_WAIT) begin
                            dataR_q <= memLoad_d;
                        end
                        state_q    <= IDLE;
                        memWrReq_q <= 1'b0;
                        memRdReq_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else if (timeoutHit) begin
                        state_q    <= IDLE;
                        memWrReq_q <= 1'b0;
                        memRdReq_q <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                    end else begin
                        timeoutCnt_q <= timeoutCnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    memWrReq_q <= 1'b0;
                    memRdReq_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus_out    = rdr ? dataR_q : '0;
    assign r_direct   = dataR_q[MEM_W-1:0];
    assign mem_wdata  = dataR_q[MEM_W-1:0];
    assign mem_wr_req = memWrReq_q;
    assign mem_rd_req = memRdReq_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mdr_handshake.sv
// Randomized bench for mdr_handshake: each transaction's outcome is predicted from its ack delay
// against the timeout, and every cycle's outputs are compared with that prediction.
module tb_mdr_handshake;

    localparam int BUS_W   = 20;
    localparam int MEM_W   = 10;
    localparam int TIMEOUT = 15;

    logic             clk;
    logic             rst;
    logic [BUS_W-1:0] bus_in;
    logic [BUS_W-1:0] bus_out;
    logic             rdr;
    logic [MEM_W-1:0] r_direct;
    logic             mem_write;
    logic             mem_read;
    logic             mem_wr_req;
    logic             mem_rd_req;
    logic [MEM_W-1:0] mem_wdata;
    logic [MEM_W-1:0] mem_rdata;
    logic             mem_ack;
    logic             busy;
    logic             done;
    logic             err;

    int checkCount = 0;
    int errorCount = 0;

    logic [BUS_W-1:0] expR;
    logic             expErr;

    mdr_handshake #(.BUS_W(BUS_W), .MEM_W(MEM_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .rdr       (rdr),
        .r_direct  (r_direct),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_wr_req(mem_wr_req),
        .mem_rd_req(mem_rd_req),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BUS_W-1:0] refExtend(input logic [MEM_W-1:0] v);
        logic [BUS_W-1:0] res;
`ifdef MDR_SIGN_EXT_EN
        res = v[MEM_W-1] ? ({BUS_W{1'b1}} << MEM_W) | BUS_W'(v) : BUS_W'(v);
`else
        res = BUS_W'(v);
`endif
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Samples one time unit after the falling edge, so inputs set here apply at the next edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic expBusy, input logic expWr,
                              input logic expRd, input logic expDone);
        checkOutput({tag, ".busy"},     32'(busy),       32'(expBusy));
        checkOutput({tag, ".wrReq"},    32'(mem_wr_req), 32'(expWr));
        checkOutput({tag, ".rdReq"},    32'(mem_rd_req), 32'(expRd));
        checkOutput({tag, ".done"},     32'(done),       32'(expDone));
        checkOutput({tag, ".err"},      32'(err),        32'(expErr));
        checkOutput({tag, ".rDirect"},  32'(r_direct),   32'(expR[MEM_W-1:0]));
        checkOutput({tag, ".memWdata"}, 32'(mem_wdata),  32'(expR[MEM_W-1:0]));
        checkOutput({tag, ".busOut"},   32'(bus_out),    rdr ? 32'(expR) : 32'd0);
    endtask

    // kind: 0 write, 1 read, 2 write+read together. ackDelay: edges after the command edge
    // at which mem_ack is sampled; 0 means never acked.
    task automatic applyStimulus(input string tag, input int kind, input logic [BUS_W-1:0] data,
                                 input int ackDelay, input bit noise);
        bit isWrite;
        bit success;
        int limit;
        isWrite   = (kind != 1);
        success   = (ackDelay != 0) && (ackDelay <= TIMEOUT);
        limit     = success ? ackDelay : TIMEOUT;
        mem_write = isWrite;
        mem_read  = (kind != 0);
        bus_in    = isWrite ? data : BUS_W'($urandom);
        mem_ack   = 1'b0;
        rdr       = 1'($urandom_range(0, 1));
        tick();
        mem_write = 1'b0;
        mem_read  = 1'b0;
        expErr    = 1'b0;
        if (isWrite) expR = refExtend(data[MEM_W-1:0]);
        for (int k = 1; k <= limit; k++) begin
            checkState({tag, ".wait"}, 1'b1, isWrite, !isWrite, 1'b0);
            if (noise) begin
                mem_write = 1'($urandom_range(0, 1));
                mem_read  = 1'($urandom_range(0, 1));
                bus_in    = BUS_W'($urandom);
            end
            rdr       = 1'($urandom_range(0, 1));
            mem_ack   = (k == ackDelay);
            mem_rdata = (k == ackDelay) ? data[MEM_W-1:0] : MEM_W'($urandom);
            tick();
        end
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_ack   = 1'b0;
        if (success) begin
            if (!isWrite) expR = refExtend(data[MEM_W-1:0]);
        end else begin
            expErr = 1'b1;
        end
        checkState({tag, ".end"}, 1'b0, 1'b0, 1'b0, success);
        // A late ack arriving while idle must change nothing.
        mem_ack   = (ackDelay > TIMEOUT);
        mem_rdata = MEM_W'($urandom);
        tick();
        mem_ack = 1'b0;
        checkState({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic applyMidReset(input string tag, input int waitCycles);
        mem_read = 1'b1;
        tick();
        mem_read = 1'b0;
        expErr   = 1'b0;
        for (int k = 0; k < waitCycles; k++) tick();
        checkState({tag, ".pre"}, 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        expR = '0;
        checkState({tag, ".rst"}, 1'b0, 1'b0, 1'b0, 1'b0);
        mem_ack   = 1'b1;
        mem_rdata = MEM_W'($urandom);
        tick();
        mem_ack = 1'b0;
        checkState({tag, ".ack"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        rdr       = 1'b1;
        bus_in    = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        expR   = '0;
        expErr = 1'b0;
        checkState("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.busOutZero", 32'(bus_out), 32'd0);

        applyStimulus("tp2write", 0, 20'hABCDE, 2, 1'b0);
        rdr = 1'b1;
        #1;
        checkOutput("tp2.busOut", 32'(bus_out), 32'h000DE);

        applyStimulus("tp3read", 1, 20'h00155, 3, 1'b0);
        rdr = 1'b1;
        #1;
        checkOutput("tp3.busOut", 32'(bus_out), 32'h00155);

        applyStimulus("tp4prep", 0, 20'h00012, 1, 1'b0);
        applyStimulus("tp4timeout", 1, 20'h003FF, 0, 1'b0);
        rdr = 1'b1;
        #1;
        checkOutput("tp4.keepR", 32'(bus_out), 32'h00012);
        checkOutput("tp4.err", 32'(err), 32'd1);
        applyStimulus("tp4clear", 0, 20'h00033, 4, 1'b0);

        applyStimulus("tp5both", 2, 20'h00077, 3, 1'b1);
        rdr = 1'b1;
        #1;
        checkOutput("tp5.busOut", 32'(bus_out), 32'h00077);

        applyStimulus("edgeAck", 1, 20'h002A5, TIMEOUT, 1'b0);
        applyStimulus("signRead", 1, 20'h003F0, 1, 1'b0);
        rdr = 1'b1;
        #1;
`ifdef MDR_SIGN_EXT_EN
        checkOutput("signRead.busOut", 32'(bus_out), 32'hFFFF0);
`else
        checkOutput("signRead.busOut", 32'(bus_out), 32'h003F0);
`endif

        applyMidReset("tp6", 2);

        for (int t = 0; t < 40; t++) begin
            int delay;
            if ($urandom_range(0, 1) == 1) delay = $urandom_range(1, 4);
            else delay = $urandom_range(0, TIMEOUT + 3);
            if ($urandom_range(0, 9) == 0) applyMidReset("rndRst", $urandom_range(0, 5));
            applyStimulus("rnd", $urandom_range(0, 2), BUS_W'($urandom), delay, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
